// File: rtl/tone_decoder.sv
// -----------------------------------------------------------------------------
// tone_decoder
//   Listens to a square-wave tone on audio_in and measures its period in
//   CLK_50M cycles. Works out which of the 8 organ notes (Do..DO2) is playing.
//   Reports the note as the organ's 4-bit switch code and as 4 ASCII chars.
//
// Ports
//   CLK_50M       in   1   system clock
//   Reset         in   1   synchronous, active-high reset
//   audio_in      in   1   asynchronous square-wave tone
//   note_code     out  4   switch code of the detected note, 4'b0000 = Off
//   info          out  32  ASCII text, MS byte = first char
//   note_valid    out  1   high while note_code != 0
//   note_changed  out  1   one-cycle pulse when note_code/info change
//   period_out    out  18  last measured full period, CLK_50M cycles
//
// Parameters
//   TOL           +/- acceptance window around each nominal period
//   MATCH_COUNT   equal consecutive classifications needed before outputs move
//   TIMEOUT       cycles without a rising edge before the tone counts as Off
//   DEGLITCH_CYC  input stability requirement (only with TONE_DEGLITCH_EN)
//   NOM           nominal periods, index 0 = Do ... index 7 = DO2
//
// Build option
//   TONE_DEGLITCH_EN  when defined, a stability filter sits after the
//                     synchronizer. Rise latency grows by DEGLITCH_CYC and the
//                     measured period does not change.
// -----------------------------------------------------------------------------
module tone_decoder #(
  parameter int              TOL          = 1024,
  parameter int              MATCH_COUNT  = 2,
  parameter int              TIMEOUT      = 200000,
  parameter int              DEGLITCH_CYC = 8,
  parameter logic [7:0][17:0] NOM         = {18'd47802, 18'd50660, 18'd56820, 18'd63858,
                                             18'd71634, 18'd75874, 18'd85180, 18'd93986}
) (
  input  logic        CLK_50M,
  input  logic        Reset,
  input  logic        audio_in,
  output logic [3:0]  note_code,
  output logic [31:0] info,
  output logic        note_valid,
  output logic        note_changed,
  output logic [17:0] period_out
);

  localparam int           MW      = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT + 1) : 1;
  localparam logic [MW-1:0] MC     = MW'(MATCH_COUNT);
  localparam logic [17:0]  TMO     = 18'(TIMEOUT);
  localparam logic [18:0]  TOL_W   = 19'(TOL);
  localparam logic [31:0]  OFF_TXT = 32'h4F666620;  // "Off "

  // Switch codes in the same order as NOM (Do first).
  localparam logic [7:0][3:0] CODE = {4'b1001, 4'b1011, 4'b1111, 4'b1101,
                                      4'b0101, 4'b0111, 4'b0011, 4'b0001};

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_TRACK} state_t;

  // Maps a switch code to its display text. Unknown codes read as Off.
  function automatic logic [31:0] code_txt(input logic [3:0] c);
    logic [31:0] t;
    case (c)
      4'b0001: t = 32'h446F2020;  // "Do  "
      4'b0011: t = 32'h52652020;  // "Re  "
      4'b0111: t = 32'h4D692020;  // "Mi  "
      4'b0101: t = 32'h46612020;  // "Fa  "
      4'b1101: t = 32'h536F2020;  // "So  "
      4'b1111: t = 32'h4C612020;  // "La  "
      4'b1011: t = 32'h53692020;  // "Si  "
      4'b1001: t = 32'h444F3220;  // "DO2 "
      default: t = OFF_TXT;
    endcase
    return t;
  endfunction

  // First note whose window contains p. The scan runs high to low, so the
  // lowest index wins when windows overlap.
  function automatic logic [3:0] classify(input logic [18:0] p);
    logic [3:0]  c;
    logic [18:0] nom;
    logic [18:0] diff;
    c = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      nom  = {1'b0, NOM[i]};
      diff = (p >= nom) ? (p - nom) : (nom - p);
      if (diff <= TOL_W) c = CODE[i];
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-FF synchronizer, optional deglitch, rise detect
  // ---------------------------------------------------------------------------
  logic s1_q, s2_q;
  logic lvl;

  always_ff @(posedge CLK_50M) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= audio_in;
      s2_q <= s1_q;
    end
  end

`ifdef TONE_DEGLITCH_EN
  localparam int            DW = $clog2(DEGLITCH_CYC + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEGLITCH_CYC - 1);

  logic          filt_q;
  logic [DW-1:0] stab_q;

  // stab_q counts cycles in which the synchronized level has differed from the
  // filtered level. Any return to the old level restarts the count, so only a
  // level held for DEGLITCH_CYC cycles gets through.
  always_ff @(posedge CLK_50M) begin
    if (Reset) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (s2_q == filt_q) begin
      stab_q <= '0;
    end else if (stab_q == DLAST) begin
      filt_q <= s2_q;
      stab_q <= '0;
    end else begin
      stab_q <= stab_q + 1'b1;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  logic prev_q, rise_q;

  always_ff @(posedge CLK_50M) begin
    if (Reset) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= lvl;
      rise_q <= lvl & ~prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter. Cleared by a rise and saturating at TIMEOUT. In the rise
  // cycle it holds (period - 1).
  // ---------------------------------------------------------------------------
  logic [17:0] cnt_q;

  always_ff @(posedge CLK_50M) begin
    if (Reset)              cnt_q <= '0;
    else if (rise_q)        cnt_q <= '0;
    else if (cnt_q != TMO)  cnt_q <= cnt_q + 18'd1;
  end

  logic [18:0] p_c;
  assign p_c = {1'b0, cnt_q} + 19'd1;

  // ---------------------------------------------------------------------------
  // Candidate tracking for the current measurement
  // ---------------------------------------------------------------------------
  state_t         state_q;
  logic [3:0]     cand_q;
  logic [MW-1:0]  match_q;
  logic [3:0]     code_q;
  logic [31:0]    info_q;
  logic           valid_q;
  logic           chg_q;
  logic [17:0]    per_q;

  logic [3:0]     cls_c;
  logic [3:0]     cand_d;
  logic [MW-1:0]  match_d;

  always_comb begin
    cls_c   = classify(p_c);
    cand_d  = cls_c;
    match_d = MW'(1);
    if (cls_c == cand_q) begin
      cand_d  = cand_q;
      match_d = (match_q == MC) ? match_q : match_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. A rise takes priority over a timeout
  // in the same cycle: the counter clears and the period is measured.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_50M) begin
    if (Reset) begin
      state_q <= S_OFF;
      cand_q  <= 4'b0000;
      match_q <= '0;
      code_q  <= 4'b0000;
      info_q  <= OFF_TXT;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      per_q   <= '0;
    end else begin
      chg_q <= 1'b0;
      if (rise_q) begin
        case (state_q)
          S_OFF: state_q <= S_ARMED;  // first edge only starts the counter
          default: begin
            // An ARMED rise measures the first full period, just like TRACK.
            state_q <= S_TRACK;
            per_q   <= p_c[17:0];
            cand_q  <= cand_d;
            match_q <= match_d;
            if (match_d == MC && cand_d != code_q) begin
              code_q  <= cand_d;
              info_q  <= code_txt(cand_d);
              valid_q <= (cand_d != 4'b0000);
              chg_q   <= 1'b1;
            end
          end
        endcase
      end else if (cnt_q == TMO && state_q != S_OFF) begin
        state_q <= S_OFF;
        cand_q  <= 4'b0000;
        match_q <= '0;
        if (code_q != 4'b0000) begin
          code_q  <= 4'b0000;
          info_q  <= OFF_TXT;
          valid_q <= 1'b0;
          chg_q   <= 1'b1;
        end
      end
    end
  end

  assign note_code    = code_q;
  assign info         = info_q;
  assign note_valid   = valid_q;
  assign note_changed = chg_q;
  assign period_out   = per_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder. The nominal periods, tolerance and timeout
// are scaled down so that the full sequence runs in a few tens of thousands of
// cycles. Window gaps and edge cases keep the same shape as at full scale.
module tb_tone_decoder;
  localparam int TOL = 40;
  localparam int MC  = 2;
  localparam int TMO = 3000;
  localparam int DG  = 8;
  // Do=2000 Re=1800 Mi=1600 Fa=1500 So=1300 La=1100 Si=1000 DO2=900
  localparam logic [7:0][17:0] NOM = {18'd900, 18'd1000, 18'd1100, 18'd1300,
                                      18'd1500, 18'd1600, 18'd1800, 18'd2000};

  localparam logic [31:0] T_OFF = 32'h4F666620;
  localparam logic [31:0] T_DO  = 32'h446F2020;
  localparam logic [31:0] T_DO2 = 32'h444F3220;
  localparam logic [31:0] T_LA  = 32'h4C612020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aud = 1'b0;
  logic [3:0]  note_code;
  logic [31:0] info;
  logic        note_valid;
  logic        note_changed;
  logic [17:0] period_out;

  tone_decoder #(
    .TOL(TOL), .MATCH_COUNT(MC), .TIMEOUT(TMO), .DEGLITCH_CYC(DG), .NOM(NOM)
  ) dut (
    .CLK_50M(clk), .Reset(rst), .audio_in(aud),
    .note_code(note_code), .info(info), .note_valid(note_valid),
    .note_changed(note_changed), .period_out(period_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] txt;
    logic [17:0] per;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [3:0] c, input logic [31:0] t, input logic [17:0] p);
    exp_t x;
    x.code = c; x.txt = t; x.per = p;
    sbq.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n full periods of length per, each starting with a rising edge
  task automatic tone(input int per, input int n);
    for (int k = 0; k < n; k++) begin
      aud = 1'b1; cyc(per / 2);
      aud = 1'b0; cyc(per - per / 2);
    end
  endtask

  // Bounded wait for every expected pulse to have been seen
  task automatic drain(input string nm, input int lim);
    for (int i = 0; i < lim && sbq.size() != 0; i++) cyc(1);
    chk({"pending_", nm}, sbq.size(), 0);
    sbq.delete();
  endtask

  // Monitor: every note_changed pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && note_changed) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: note_code=%h info=%h with nothing expected",
                 note_code, info);
      end else begin
        e = sbq.pop_front();
        chk("code",   {28'd0, note_code},  {28'd0, e.code});
        chk("info",   info,                e.txt);
        chk("valid",  {31'd0, note_valid}, {31'd0, (e.code != 4'd0)});
        chk("period", {14'd0, period_out}, {14'd0, e.per});
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    rst = 1'b1; aud = 1'b0;
    cyc(5);
    chk("rst_info",   info,                 T_OFF);
    chk("rst_code",   {28'd0, note_code},   32'd0);
    chk("rst_valid",  {31'd0, note_valid},  32'd0);
    chk("rst_period", {14'd0, period_out},  32'd0);
    chk("rst_chg",    {31'd0, note_changed}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // 2: Do, reported on the 3rd rise
    push(4'b0001, T_DO, 18'd2000);
    tone(2000, 4);
    drain("do", 10);
    chk("do_period", {14'd0, period_out}, 32'd2000);

    // 3: one Re period, then DO2. Re alone must not update.
    tone(1800, 1);
    tone(900, 1);
    chk("re_period", {14'd0, period_out}, 32'd1800);
    chk("re_hold",   {28'd0, note_code},  32'h1);
    push(4'b1001, T_DO2, 18'd900);
    tone(900, 2);
    drain("do2", 10);

    // 4: stop toggling -> Off after the timeout
    push(4'b0000, T_OFF, 18'd900);
    drain("timeout", TMO + 200);
    chk("to_code", {28'd0, note_code}, 32'd0);
    // a lone rise only arms the detector
    aud = 1'b1; cyc(100);
    aud = 1'b0; cyc(TMO + 200);
    chk("lone_code",   {28'd0, note_code},  32'd0);
    chk("lone_period", {14'd0, period_out}, 32'd900);

    // 5: La, then a between-window period, then the tolerance edges
    push(4'b1111, T_LA, 18'd1100);
    tone(1100, 3);
    drain("la", 10);
    push(4'b0000, T_OFF, 18'd1200);
    tone(1200, 3);
    drain("gap", 10);
    chk("gap_period", {14'd0, period_out}, 32'd1200);
    push(4'b1111, T_LA, 18'd1140);
    tone(1140, 3);
    drain("la_tol", 10);
    push(4'b0000, T_OFF, 18'd1141);
    tone(1141, 3);
    drain("la_out", 10);

    // 6: track Do again, then reset mid-period
    push(4'b0001, T_DO, 18'd2000);
    tone(2000, 3);
    drain("do_again", 10);
`ifdef TONE_DEGLITCH_EN
    // 3-cycle high glitch inside the low half of a Do period
    aud = 1'b1; cyc(1000);
    aud = 1'b0; cyc(500);
    aud = 1'b1; cyc(3);
    aud = 1'b0; cyc(497);
    tone(2000, 2);
    chk("glitch_code", {28'd0, note_code}, 32'h1);
    chk("glitch_per",  {14'd0, period_out}, 32'd2000);
`endif
    aud = 1'b1; cyc(700);
    rst = 1'b1; aud = 1'b0;
    cyc(1);
    chk("mid_code",   {28'd0, note_code},   32'd0);
    chk("mid_info",   info,                 T_OFF);
    chk("mid_valid",  {31'd0, note_valid},  32'd0);
    chk("mid_period", {14'd0, period_out},  32'd0);
    chk("mid_chg",    {31'd0, note_changed}, 32'd0);
    rst = 1'b0;
    cyc(50);
    chk("post_code", {28'd0, note_code}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
